fifo_sync_param: RTL and testbench

//  Single-clock FIFO, next generation of the team's buffer block. Width, depth,

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_regfile.sv | 31 +++
 rtl/fifo_sync_param.sv | 145 ++++++++++++++
 tb/tb_fifo_sync_param.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: default sizes and
// helpers that derive depth and count width from the pointer width.
package fifo_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 4;

  // Number of words addressed by an addr_w-bit pointer
  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Count must represent 0..DEPTH inclusive, hence one extra bit
  function automatic int unsigned fifo_cnt_w(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W storage array: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is combinational so the top level can use it for fall-through
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO with watermarks, optional first-word
// fall-through, synchronous flush and sticky overflow/underflow flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);
  localparam int unsigned CNT_W = fifo_cnt_w(ADDR_W);

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntAf   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CntAe   = CNT_W'(AE_LEVEL);

  // Elaboration-time parameter legality checks
  if (ADDR_W < 1) begin : g_bad_addr_w
    $error("fifo_sync_param: ADDR_W must be at least 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] rd_data;

  // Flags decode from the registered count only
  always_comb begin
    full         = (count_q == CntFull);
    empty        = (count_q == '0);
    almost_full  = (count_q >= CntAf);
    almost_empty = (count_q <= CntAe);
  end

  // Accept qualification; rst also blocks the storage write during reset
  always_comb begin
    wr_ok = wr_en & ~full & ~flush & ~rst;
    rd_ok = rd_en & ~empty & ~flush & ~rst;
  end

  // Next-state for pointers, count and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // Set has priority over clr_err
    overflow_d  = (wr_en & full & ~flush) | (overflow_q & ~clr_err);
    underflow_d = (rd_en & empty & ~flush) | (underflow_q & ~clr_err);
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; meaningless while empty
    assign dout = rd_data;
  end else begin : g_reg_read
    logic [DATA_W-1:0] dout_q;

    // Registered read: load on pop, hold otherwise, clear on flush
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (flush) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= rd_data;
      end
    end

    assign dout = dout_q;
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param: a registered-read
// instance (u_dut) and a fall-through instance (u_fwft).
module tb_fifo_sync_param;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Registered-read instance
  logic          flush, wr_en, rd_en, clr_err;
  logic [DW-1:0] din, dout;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  // Fall-through instance
  logic          f_flush, f_wr_en, f_rd_en, f_clr_err;
  logic [DW-1:0] f_din, f_dout;
  logic          f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [AW:0]   f_count;

  int vectors;
  int miscompares;

  fifo_sync_param #(
    .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  fifo_sync_param #(
    .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
    .underflow(f_underflow), .clr_err(f_clr_err)
  );

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 110000",
               {empty, almost_empty, full, almost_full, overflow, underflow});
    end
    vectors++;
    if (count !== 5'd0 || dout !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_count_dout: got count=%0d dout=%0h want 0/0", count, dout);
    end
    vectors++;
    if (f_empty !== 1'b1 || f_count !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_fwft: got empty=%b count=%0d want 1/0", f_empty, f_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = 32'(i);
      step();
      vectors++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i + 1 == 16)
          || almost_empty !== (i + 1 <= 2) || empty !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_%0d: got count=%0d af=%b full=%b ae=%b empty=%b", i, count,
                 almost_full, full, almost_empty, empty);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      vectors++;
      if (dout !== 32'(i) || count !== 5'(15 - i) || almost_empty !== (15 - i <= 2)) begin
        miscompares++;
        $display("FAIL drain_%0d: got dout=%0h count=%0d ae=%b want dout=%0h count=%0d",
                 i, dout, count, almost_empty, i, 15 - i);
      end
    end
    rd_en = 1'b0;
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: got empty=%b full=%b want 1/0", empty, full);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      din   = 32'(100 + i);
      step();
    end
    vectors++;
    if (count !== 5'd5) begin
      miscompares++;
      $display("FAIL b2b_prefill: got count=%0d want 5", count);
    end
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = 32'(105 + k);
      step();
      vectors++;
      if (count !== 5'd5 || dout !== 32'(100 + k)) begin
        miscompares++;
        $display("FAIL b2b_%0d: got count=%0d dout=%0d want 5/%0d", k, count, dout, 100 + k);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      step();
      vectors++;
      if (dout !== 32'(120 + i)) begin
        miscompares++;
        $display("FAIL b2b_drain_%0d: got %0d want %0d", i, dout, 120 + i);
      end
    end
    rd_en = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = 32'(200 + i);
      step();
    end
    din = 32'hDEAD;
    step();
    wr_en = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || count !== 5'd16 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_set: got ovf=%b count=%0d udf=%b want 1/16/0",
               overflow, count, underflow);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      vectors++;
      if (dout !== 32'(200 + i)) begin
        miscompares++;
        $display("FAIL ovf_data_%0d: got %0h want %0h", i, dout, 200 + i);
      end
    end
    // Pop attempt on an empty FIFO
    step();
    rd_en = 1'b0;
    vectors++;
    if (underflow !== 1'b1 || dout !== 32'd215 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL underflow_set: got udf=%b dout=%0d count=%0d want 1/215/0",
               underflow, dout, count);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_err: got ovf=%b udf=%b want 0/0", overflow, underflow);
    end
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = 32'(300 + i);
      step();
    end
    step();
    // New overflow together with clr_err: set must win
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    wr_en   = 1'b0;
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || count !== 5'd0 || dout !== 32'd0) begin
      miscompares++;
      $display("FAIL ovf_persist_flush: got ovf=%b count=%0d dout=%0h want 1/0/0",
               overflow, count, dout);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_final_clr: got %b want 0", overflow);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1;
      din   = 32'(50 + i);
      step();
    end
    vectors++;
    if (count !== 5'd9) begin
      miscompares++;
      $display("FAIL flush_prefill: got %0d want 9", count);
    end
    // Produce a non-zero dout first so the clear is observable
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    wr_en = 1'b1;
    flush = 1'b1;
    din   = 32'h1234;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || dout !== 32'd0 || overflow !== 1'b0
        || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL flush: got count=%0d empty=%b dout=%0h ovf=%b udf=%b", count, empty,
               dout, overflow, underflow);
    end
    wr_en = 1'b1;
    din   = 32'h77;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    vectors++;
    if (dout !== 32'h77 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_after: got dout=%0h empty=%b want 77/1", dout, empty);
    end
  endtask

  task automatic test_fwft();
    f_wr_en = 1'b1;
    f_din   = 32'hA5;
    step();
    f_wr_en = 1'b0;
    vectors++;
    if (f_empty !== 1'b0 || f_dout !== 32'hA5) begin
      miscompares++;
      $display("FAIL fwft_head: got empty=%b dout=%0h want 0/a5", f_empty, f_dout);
    end
    f_wr_en = 1'b1;
    f_din   = 32'hB6;
    step();
    f_wr_en = 1'b0;
    vectors++;
    if (f_dout !== 32'hA5 || f_count !== 5'd2) begin
      miscompares++;
      $display("FAIL fwft_hold: got dout=%0h count=%0d want a5/2", f_dout, f_count);
    end
    f_rd_en = 1'b1;
    step();
    vectors++;
    if (f_dout !== 32'hB6 || f_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL fwft_pop1: got dout=%0h empty=%b want b6/0", f_dout, f_empty);
    end
    step();
    f_rd_en = 1'b0;
    vectors++;
    if (f_empty !== 1'b1 || f_count !== 5'd0 || f_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fwft_pop2: got empty=%b count=%0d udf=%b want 1/0/0",
               f_empty, f_count, f_underflow);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1;
      din   = 32'(400 + i);
      step();
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    vectors++;
    if (count !== 5'd7 || dout !== 32'd400) begin
      miscompares++;
      $display("FAIL rst_prefill: got count=%0d dout=%0d want 7/400", count, dout);
    end
    // Mid-cycle, away from any edge
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0
        || dout !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_async: got count=%0d empty=%b ae=%b full=%b dout=%0h",
               count, empty, almost_empty, full, dout);
    end
    step();
    vectors++;
    if (count !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_no_accept: got count=%0d want 0", count);
    end
    #2;
    rst   = 1'b0;
    wr_en = 1'b0;
    step();
    vectors++;
    if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release: got empty=%b ovf=%b udf=%b", empty, overflow, underflow);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    clr_err   = 1'b0;
    din       = '0;
    f_flush   = 1'b0;
    f_wr_en   = 1'b0;
    f_rd_en   = 1'b0;
    f_clr_err = 1'b0;
    f_din     = '0;
    #12;
    test_reset();
    step();
    test_fill_drain();
    test_back_to_back();
    test_errors();
    test_flush();
    test_fwft();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
